// File: rtl/delta_pkg.sv
// delta_pkg: shared state encoding, default widths, underflow window and iteration count
// for the delta_mul95 shift-add multiplier.
package delta_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DELTA_A_W = 48;
    localparam int DELTA_B_W = 47;
    localparam int DELTA_P_W = DELTA_A_W + DELTA_B_W;
    localparam int UFLOW_MSB = 94;
    localparam int UFLOW_LSB = 43;
    function automatic int num_iter(input int b_w, input int bpc);
        return (b_w + bpc - 1) / bpc;
    endfunction
endpackage

// File: rtl/delta_pp_add.sv
// delta_pp_add: adds one shifted partial product (b_slice * a) << shift to the accumulator.
module delta_pp_add
    import delta_pkg::*;
#(
    parameter int A_W  = DELTA_A_W,
    parameter int BPC  = 1,
    parameter int P_W  = DELTA_P_W,
    parameter int SH_W = 6
) (
    input  logic [P_W-1:0]  acc,
    input  logic [A_W-1:0]  a,
    input  logic [BPC-1:0]  b_slice,
    input  logic [SH_W-1:0] shift,
    output logic [P_W-1:0]  acc_next
);
    localparam int PP_W = A_W + BPC;
    logic [PP_W-1:0] pp;
    assign pp = PP_W'(a) * PP_W'(b_slice);
    assign acc_next = acc + (P_W'(pp) << shift);
endmodule

// File: rtl/delta_mul95.sv
// delta_mul95: sequential unsigned shift-add multiplier producing the 95-bit delta word.
// Define DELTA_UFLOW_FLAG_EN to add the registered underflow output.
module delta_mul95
    import delta_pkg::*;
#(
    parameter int A_W = DELTA_A_W,
    parameter int B_W = DELTA_B_W,
    parameter int BPC = 1,
    localparam int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] delta
`ifdef DELTA_UFLOW_FLAG_EN
    ,
    output logic           underflow
`endif
);
    localparam int N     = num_iter(B_W, BPC);
    localparam int CNT_W = $clog2(N + 1);
    localparam int BS_W  = N * BPC;
    localparam int SH_W  = $clog2(BS_W);
    state_t state, state_nxt;
    logic [A_W-1:0]   a_q;
    logic [BS_W-1:0]  b_sh;
    logic [P_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shift;
    logic             last;
    assign last  = cnt == CNT_W'(N - 1);
    assign shift = SH_W'(cnt * BPC);
    assign delta = acc;
    delta_pp_add #(.A_W(A_W), .BPC(BPC), .P_W(P_W), .SH_W(SH_W)) u_pp (
        .acc      (acc),
        .a        (a_q),
        .b_slice  (b_sh[BPC-1:0]),
        .shift    (shift),
        .acc_next (acc_nxt)
    );
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nxt = (state == IDLE && in_valid) ? BUSY :
                    (state == BUSY && last)     ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end
    // b is consumed LSB first from a zero-padded shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (in_valid && in_ready) begin
                a_q  <= a;
                b_sh <= BS_W'(b);
                acc  <= '0;
                cnt  <= '0;
            end else if (state == BUSY) begin
                acc  <= acc_nxt;
                b_sh <= b_sh >> BPC;
                cnt  <= cnt + 1'b1;
            end
        end
    end
`ifdef DELTA_UFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underflow <= 1'b0;
        else underflow <= state_nxt == DONE &&
                          (state == DONE ? underflow : acc_nxt[UFLOW_MSB:UFLOW_LSB] == '0);
    end
`endif
endmodule

// File: tb/tb_delta_mul95.sv
// tb_delta_mul95: directed checks of delta_mul95 at BPC=1 with BPC=2/4 instances alongside.
module tb_delta_mul95;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [47:0] a = '0;
    logic [46:0] b = '0;
    logic        ir1, ir2, ir4, ov1, ov2, ov4;
    logic [94:0] dl1, dl2, dl4;
    logic        uf1, uf2, uf4;
    int          n_cmp = 0, n_bad = 0;
    int          lat1, lat2, lat4;
    logic [94:0] d1, d2, d4;
    logic        u1;

    always #5 clk = ~clk;

`ifdef DELTA_UFLOW_FLAG_EN
    delta_mul95 #(.BPC(1)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .delta(dl1), .underflow(uf1));
    delta_mul95 #(.BPC(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .out_valid(ov2), .out_ready(out_ready), .delta(dl2), .underflow(uf2));
    delta_mul95 #(.BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b),
        .out_valid(ov4), .out_ready(out_ready), .delta(dl4), .underflow(uf4));
`else
    assign uf1 = 1'b0;
    assign uf2 = 1'b0;
    assign uf4 = 1'b0;
    delta_mul95 #(.BPC(1)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .delta(dl1));
    delta_mul95 #(.BPC(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .out_valid(ov2), .out_ready(out_ready), .delta(dl2));
    delta_mul95 #(.BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b),
        .out_valid(ov4), .out_ready(out_ready), .delta(dl4));
`endif

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Handshake once, scramble the operands, then record each instance's first valid cycle.
    task automatic do_op(input logic [47:0] ia, input logic [46:0] ib);
        lat1 = -1; lat2 = -1; lat4 = -1;
        d1 = 'x; d2 = 'x; d4 = 'x; u1 = 1'bx;
        a = ia; b = ib; in_valid = 1;
        step();
        in_valid = 0; a = ~ia; b = ~ib;
        for (int c = 1; c <= 80 && lat1 < 0; c++) begin
            step();
            if (ov1 && lat1 < 0) begin lat1 = c; d1 = dl1; u1 = uf1; end
            if (ov2 && lat2 < 0) begin lat2 = c; d2 = dl2; end
            if (ov4 && lat4 < 0) begin lat4 = c; d4 = dl4; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        n_cmp += 3;
        if (ir1 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", ir1); end
        if (ov1 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", ov1); end
        if (dl1 !== '0) begin n_bad++; $display("FAIL reset_delta got=%h exp=0", dl1); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (uf1 !== 1'b0) begin n_bad++; $display("FAIL reset_underflow got=%b exp=0", uf1); end
`endif
        @(posedge clk); #1;
        rst_n = 1;
        step();
    endtask

    task automatic test_power2();
        do_op(48'h1 << 47, 47'h1 << 46);
        n_cmp += 2;
        if (lat1 !== 47) begin n_bad++; $display("FAIL pow2_latency got=%0d exp=47", lat1); end
        if (d1 !== (95'h1 << 93)) begin n_bad++; $display("FAIL pow2_delta got=%h exp=%h", d1, 95'h1 << 93); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (u1 !== 1'b0) begin n_bad++; $display("FAIL pow2_underflow got=%b exp=0", u1); end
`endif
        step();
    endtask

    task automatic test_bpc();
        logic [94:0] exp_max;
        exp_max = 95'h7FFF_FFFF_FFFE_8000_0000_0001;
        do_op(48'hFFFF_FFFF_FFFF, 47'h7FFF_FFFF_FFFF);
        n_cmp += 6;
        if (d1 !== exp_max) begin n_bad++; $display("FAIL max_delta_bpc1 got=%h exp=%h", d1, exp_max); end
        if (d2 !== exp_max) begin n_bad++; $display("FAIL max_delta_bpc2 got=%h exp=%h", d2, exp_max); end
        if (d4 !== exp_max) begin n_bad++; $display("FAIL max_delta_bpc4 got=%h exp=%h", d4, exp_max); end
        if (lat1 !== 47) begin n_bad++; $display("FAIL latency_bpc1 got=%0d exp=47", lat1); end
        if (lat2 !== 24) begin n_bad++; $display("FAIL latency_bpc2 got=%0d exp=24", lat2); end
        if (lat4 !== 12) begin n_bad++; $display("FAIL latency_bpc4 got=%0d exp=12", lat4); end
        step();
    endtask

    task automatic test_zero();
        do_op(48'h0, 47'h5A5A_5A5A_5A5A);
        n_cmp += 3;
        if (d1 !== '0) begin n_bad++; $display("FAIL zero_delta got=%h exp=0", d1); end
        if (lat1 !== 47) begin n_bad++; $display("FAIL zero_latency got=%0d exp=47", lat1); end
        if (d4 !== '0) begin n_bad++; $display("FAIL zero_delta_bpc4 got=%h exp=0", d4); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (u1 !== 1'b1) begin n_bad++; $display("FAIL zero_underflow got=%b exp=1", u1); end
`endif
        step();
    endtask

    task automatic test_uflow_edge();
        do_op(48'h1, 47'h1 << 42);
        n_cmp++;
        if (d1 !== (95'h1 << 42)) begin n_bad++; $display("FAIL b42_delta got=%h exp=%h", d1, 95'h1 << 42); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (u1 !== 1'b1) begin n_bad++; $display("FAIL b42_underflow got=%b exp=1", u1); end
`endif
        step();
        do_op(48'h1, 47'h1 << 43);
        n_cmp++;
        if (d1 !== (95'h1 << 43)) begin n_bad++; $display("FAIL b43_delta got=%h exp=%h", d1, 95'h1 << 43); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (u1 !== 1'b0) begin n_bad++; $display("FAIL b43_underflow got=%b exp=0", u1); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        do_op(48'hABCD, 47'h1234);
        n_cmp++;
        if (d1 !== 95'hC374FA4) begin n_bad++; $display("FAIL b2b_first got=%h exp=c374fa4", d1); end
        step();
        n_cmp += 2;
        if (ir1 !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got=%b exp=1", ir1); end
        if (ov1 !== 1'b0) begin n_bad++; $display("FAIL b2b_out_valid got=%b exp=0", ov1); end
        do_op(48'hFFFF_FFFF_FFFF, 47'h2);
        n_cmp += 2;
        if (d1 !== 95'h1_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL b2b_second got=%h exp=1fffffffffffe", d1); end
        if (lat1 !== 47) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=47", lat1); end
        step();
    endtask

    task automatic test_backpressure();
        int bad_hold;
        out_ready = 0;
        do_op(48'h5, 47'h7);
        n_cmp++;
        if (d1 !== 95'd35) begin n_bad++; $display("FAIL bp_delta got=%h exp=23", d1); end
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 48'h77; b = 47'h99;
            step();
            n_cmp++;
            if (dl1 !== 95'd35 || ov1 !== 1'b1 || ir1 !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle=%0d delta=%h ov=%b ir=%b exp delta=23 ov=1 ir=0", i, dl1, ov1, ir1);
            end
        end
        in_valid = 0;
        out_ready = 1;
        step();
        n_cmp += 2;
        if (ov1 !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got=%b exp=0", ov1); end
        if (ir1 !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got=%b exp=1", ir1); end
    endtask

    task automatic test_reset_mid();
        a = 48'hFFFF_0000_FFFF; b = 47'h7FFF_0000_FFFF; in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        rst_n = 0;
        #1;
        n_cmp += 3;
        if (ov1 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_out_valid got=%b exp=0", ov1); end
        if (ir1 !== 1'b1) begin n_bad++; $display("FAIL mid_reset_in_ready got=%b exp=1", ir1); end
        if (dl1 !== '0) begin n_bad++; $display("FAIL mid_reset_delta got=%h exp=0", dl1); end
        step();
        rst_n = 1;
        step();
        do_op(48'd3, 47'd5);
        n_cmp += 2;
        if (d1 !== 95'd15) begin n_bad++; $display("FAIL post_reset_delta got=%h exp=f", d1); end
        if (lat1 !== 47) begin n_bad++; $display("FAIL post_reset_latency got=%0d exp=47", lat1); end
`ifdef DELTA_UFLOW_FLAG_EN
        n_cmp++;
        if (u1 !== 1'b1) begin n_bad++; $display("FAIL post_reset_underflow got=%b exp=1", u1); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_power2();
        test_bpc();
        test_zero();
        test_uflow_edge();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
